// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with transmit FIFO
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ram_addr,
    input  logic [3:0]  ram_w,
    input  logic        ram_r,
    input  logic [31:0] ram_out,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            full, empty, push, pop, accept, ovf_set, ovf_clr, baud_end;
    logic [31:0]     status;
    logic            unused_ok;

    assign unused_ok = ^{ram_r, ram_addr[1:0], ram_w[3:1], ram_out[31:8]};

    assign sel      = (ram_addr[31:3] == BASE_ADDR[31:3]);
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push     = sel && !ram_addr[2] && ram_w[0];
    assign ovf_clr  = sel && ram_addr[2] && ram_w[0] && ram_out[3];
    assign baud_end = (baud_q == BAUD_LAST);
    assign busy     = !empty || (state_q != IDLE);
    assign tx       = tx_q;

    assign status  = {17'd0, 7'(count_q), 4'd0, ovf_q, busy, empty, full};
    assign rd_data = (sel && ram_addr[2]) ? status : 32'd0;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = 16'd0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = 16'd0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = 16'd0;
                    // Chain straight into the next frame so queued bytes leave with no idle gap
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        accept   = push && (!full || pop);
        ovf_set  = push && full && !pop;
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= ram_out[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ram_addr = 32'd0;
    logic [3:0]  ram_w = 4'd0;
    logic        ram_r = 1'b0;
    logic [31:0] ram_out = 32'd0;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  rxq [$];

    mmio_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (8),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ram_addr(ram_addr),
        .ram_w   (ram_w),
        .ram_r   (ram_r),
        .ram_out (ram_out),
        .sel     (sel),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        ram_addr = a;
        ram_out  = d;
        ram_w    = w;
        @(posedge clk);
        #1;
        ram_w = 4'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        ram_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_wave(input string tag, input logic [19:0] bits, input int nbits);
        for (int k = 0; k < nbits * 4; k++) begin
            chk($sformatf("%s[%0d]", tag, k), {31'd0, tx}, {31'd0, bits[k / 4]});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : rx_monitor
        logic [7:0] b;
        b = 8'd0;
        forever begin
            @(negedge tx);
            repeat (2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(posedge clk);
                #1;
                b[i] = tx;
            end
            repeat (4) @(posedge clk);
            #1;
            rxq.push_back(b);
        end
    end

    initial begin : stim
        logic [31:0] v;
        int          bad;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rd(BASE + 32'd4, v);
        chk("reset_status", v, 32'h0000_0002);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(BASE, v);
        chk("txdata_reads_zero", v, 32'd0);
        chk("sel_base0", {31'd0, sel}, 32'd1);

        // Single 0xA5 frame, upper lanes carry junk
        wr(BASE, 32'h1234_56A5, 4'b1111);
        chk("a5_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check_wave("a5_wave", {10'd0, 1'b1, 8'hA5, 1'b0}, 10);
        chk("a5_busy_fall", {31'd0, busy}, 32'd0);
        chk("a5_tx_idle", {31'd0, tx}, 32'd1);

        // Back-to-back frames, no idle gap between STOP and START
        rxq.delete();
        wr(BASE, 32'h5A, 4'b0001);
        wr(BASE, 32'hC3, 4'b0001);
        check_wave("b2b_wave", {1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A, 1'b0}, 20);
        wait_idle("b2b_idle");
        chk("b2b_rx_n", rxq.size(), 32'd2);
        if (rxq.size() == 2) begin
            chk("b2b_rx0", {24'd0, rxq[0]}, 32'h5A);
            chk("b2b_rx1", {24'd0, rxq[1]}, 32'hC3);
        end

        // Three pushes while transmitting
        wr(BASE, 32'h11, 4'b0001);
        wr(BASE, 32'h22, 4'b0001);
        wr(BASE, 32'h33, 4'b0001);
        rd(BASE + 32'd4, v);
        chk("status_3push", v, 32'h0000_0204);
        wait_idle("3push_idle");

        // Nine pushes fill the FIFO exactly; a tenth lands on the pop edge
        rxq.delete();
        for (int i = 1; i <= 9; i++) wr(BASE, 32'(i), 4'b0001);
        rd(BASE + 32'd4, v);
        chk("status_full", v, 32'h0000_0805);
        repeat (32) @(posedge clk);
        wr(BASE, 32'h0A, 4'b0001);
        rd(BASE + 32'd4, v);
        chk("status_push_pop_full", v, 32'h0000_0805);
        wait_idle("fill_idle");
        chk("fill_rx_n", rxq.size(), 32'd10);
        if (rxq.size() == 10) begin
            for (int i = 0; i < 10; i++) chk($sformatf("fill_rx%0d", i), {24'd0, rxq[i]}, 32'(i + 1));
        end
        rd(BASE + 32'd4, v);
        chk("fill_no_ovf", v, 32'h0000_0002);

        // Ten consecutive pushes: last one dropped, overflow sticky
        rxq.delete();
        for (int i = 1; i <= 10; i++) wr(BASE, 32'(i), 4'b0001);
        rd(BASE + 32'd4, v);
        chk("status_ovf", v, 32'h0000_080D);
        wait_idle("ovf_idle");
        chk("ovf_rx_n", rxq.size(), 32'd9);
        if (rxq.size() == 9) begin
            for (int i = 0; i < 9; i++) chk($sformatf("ovf_rx%0d", i), {24'd0, rxq[i]}, 32'(i + 1));
        end
        rd(BASE + 32'd4, v);
        chk("ovf_sticky", v, 32'h0000_000A);
        wr(BASE + 32'd4, 32'h8, 4'b0001);
        rd(BASE + 32'd4, v);
        chk("ovf_cleared", v, 32'h0000_0002);

        // Writes that must not push
        wr(BASE, 32'h77, 4'b0010);
        chk("lane1_no_push", {31'd0, busy}, 32'd0);
        rd(BASE + 32'd4, v);
        chk("lane1_status", v, 32'h0000_0002);
        wr(BASE + 32'd8, 32'h77, 4'b0001);
        chk("base8_no_push", {31'd0, busy}, 32'd0);
        rd(BASE + 32'd8, v);
        chk("base8_rd_zero", v, 32'd0);
        chk("sel_base8", {31'd0, sel}, 32'd0);

        // Reset asserted during DATA bit 3
        wr(BASE, 32'h00, 4'b0001);
        wr(BASE, 32'h00, 4'b0001);
        repeat (17) @(posedge clk);
        #1;
        chk("mid_tx_low", {31'd0, tx}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rd(BASE + 32'd4, v);
        chk("abort_status", v, 32'h0000_0002);
        @(negedge clk);
        ram_addr = BASE;
        ram_out  = 32'h55;
        ram_w    = 4'b0001;
        @(posedge clk);
        #1;
        ram_w = 4'd0;
        rd(BASE + 32'd4, v);
        chk("no_push_in_reset", v, 32'h0000_0002);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("no_frames_after_reset", 32'(bad), 32'd0);
        rd(BASE + 32'd4, v);
        chk("post_reset_status", v, 32'h0000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
